// File: rtl/jogao_pkg.sv
// rtl/jogao_pkg.sv - shared frame layout and state encodings for the jogao UART frame receiver
package jogao_pkg;

  localparam int FRAME_W       = 16;
  localparam int ESTADO_W      = 4;
  localparam int MACRO_W       = 4;
  localparam int MICRO_W       = 4;
  localparam int RES_MACRO_W   = 2;
  localparam int RES_JOGO_W    = 2;

  localparam int ESTADO_LSB    = 12;
  localparam int MACRO_LSB     = 8;
  localparam int MICRO_LSB     = 4;
  localparam int RES_MACRO_LSB = 2;
  localparam int RES_JOGO_LSB  = 0;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic {
    ASM_WAIT_HI = 1'b0,
    ASM_WAIT_LO = 1'b1
  } asm_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver with input synchronizer and mid-bit sampling
module uart_rx_byte
  import jogao_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       s_in,
  output logic [7:0] data,
  output logic       byte_done,
  output logic       stop_err,
  output logic [1:0] state
);

  localparam int TMR_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TMR_W-1:0] BIT_END  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] HALF_END = TMR_W'(CLKS_PER_BIT / 2 - 1);

  logic             s_meta_q, s_sync_q, s_prev_q;
  rx_state_e        state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;

  // Synchronizer and edge-history flops reset high so a released reset never looks like a start edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_meta_q <= 1'b1;
      s_sync_q <= 1'b1;
      s_prev_q <= 1'b1;
      state_q  <= RX_IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
    end else begin
      s_meta_q <= s_in;
      s_sync_q <= s_meta_q;
      s_prev_q <= s_sync_q;
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    stop_err  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        timer_d = '0;
        idx_d   = '0;
        if (s_prev_q && !s_sync_q) state_d = RX_START;
      end
      RX_START: begin
        if (timer_q == HALF_END) begin
          timer_d = '0;
          state_d = s_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (timer_q == BIT_END) begin
          timer_d = '0;
          shift_d = {s_sync_q, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = RX_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (timer_q == BIT_END) begin
          timer_d   = '0;
          state_d   = RX_IDLE;
          byte_done = s_sync_q;
          stop_err  = !s_sync_q;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data  = shift_q;
  assign state = state_q;

endmodule

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - two-byte frame assembler with inter-byte timeout and registered field outputs
module uart_frame_rx
  import jogao_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 20 * 434
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   s_in,
  output logic [ESTADO_W-1:0]    estado,
  output logic [MACRO_W-1:0]     macro,
  output logic [MICRO_W-1:0]     micro,
  output logic [RES_MACRO_W-1:0] resultado_macro,
  output logic [RES_JOGO_W-1:0]  resultado_jogo,
  output logic                   frame_valid,
  output logic                   frame_err,
  output logic [1:0]             db_estado_rx
);

  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TO_W-1:0] TO_END = TO_W'(TIMEOUT_CLKS - 1);

  logic [7:0]         rx_data;
  logic               rx_done, rx_stop_err;
  logic [1:0]         rx_state;

  asm_state_e         asm_q, asm_d;
  logic [7:0]         hi_q, hi_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clock    (clock),
    .reset    (reset),
    .s_in     (s_in),
    .data     (rx_data),
    .byte_done(rx_done),
    .stop_err (rx_stop_err),
    .state    (rx_state)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      asm_q   <= ASM_WAIT_HI;
      hi_q    <= '0;
      to_q    <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      asm_q   <= asm_d;
      hi_q    <= hi_d;
      to_q    <= to_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // A stop error wins over everything, so valid and err can never fire together.
  always_comb begin
    asm_d   = asm_q;
    hi_d    = hi_q;
    to_d    = to_q;
    frame_d = frame_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (rx_stop_err) begin
      asm_d = ASM_WAIT_HI;
      to_d  = '0;
      err_d = 1'b1;
    end else begin
      case (asm_q)
        ASM_WAIT_HI: begin
          to_d = '0;
          if (rx_done) begin
            hi_d  = rx_data;
            asm_d = ASM_WAIT_LO;
          end
        end
        ASM_WAIT_LO: begin
          if (rx_done) begin
            frame_d = {hi_q, rx_data};
            valid_d = 1'b1;
            asm_d   = ASM_WAIT_HI;
            to_d    = '0;
          end else if (rx_state == RX_IDLE) begin
            if (to_q == TO_END) begin
              err_d = 1'b1;
              asm_d = ASM_WAIT_HI;
              to_d  = '0;
            end else begin
              to_d = to_q + 1'b1;
            end
          end
        end
        default: asm_d = ASM_WAIT_HI;
      endcase
    end
  end

  assign estado          = frame_q[ESTADO_LSB    +: ESTADO_W];
  assign macro           = frame_q[MACRO_LSB     +: MACRO_W];
  assign micro           = frame_q[MICRO_LSB     +: MICRO_W];
  assign resultado_macro = frame_q[RES_MACRO_LSB +: RES_MACRO_W];
  assign resultado_jogo  = frame_q[RES_JOGO_LSB  +: RES_JOGO_W];
  assign frame_valid     = valid_q;
  assign frame_err       = err_q;
  assign db_estado_rx    = rx_state;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - directed self-checking bench for uart_frame_rx
module tb_uart_frame_rx;

  localparam int CPB = 4;
  localparam int TO  = 80;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       s_in  = 1'b1;
  logic [3:0] estado, macro, micro;
  logic [1:0] resultado_macro, resultado_jogo;
  logic       frame_valid, frame_err;
  logic [1:0] db_estado_rx;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int last_err_cyc = 0;
  logic [15:0] vq[$];

  wire [15:0] fields = {estado, macro, micro, resultado_macro, resultado_jogo};

  always #5 clock = ~clock;

  uart_frame_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .s_in           (s_in),
    .estado         (estado),
    .macro          (macro),
    .micro          (micro),
    .resultado_macro(resultado_macro),
    .resultado_jogo (resultado_jogo),
    .frame_valid    (frame_valid),
    .frame_err      (frame_err),
    .db_estado_rx   (db_estado_rx)
  );

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (frame_valid) begin
      valid_cnt++;
      vq.push_back(fields);
    end
    if (frame_err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (frame_valid && frame_err) both_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1 s_in = f[i];
      repeat (CPB - 1) @(posedge clock);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clock);
    #1 s_in = 1'b1;
    repeat (n - 1) @(posedge clock);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    n_cmp++; if (fields !== 16'h0000) begin n_bad++; $display("FAIL reset_fields: got %h expected %h", fields, 16'h0000); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", frame_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", frame_err); end
    n_cmp++; if (db_estado_rx !== 2'd0) begin n_bad++; $display("FAIL reset_rxstate: got %0d expected 0", db_estado_rx); end
    @(posedge clock);
    #1 reset = 1'b1;
    idle(8);
  endtask

  task automatic test_basic;
    int v0;
    v0 = valid_cnt;
    send_byte(8'h5A, 1'b1);
    send_byte(8'h3C, 1'b1);
    @(posedge clock); @(negedge clock);
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid: got %b expected 0", frame_valid); end
    @(posedge clock); @(negedge clock);
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL basic_latency: got %b expected 1", frame_valid); end
    idle(10);
    @(negedge clock);
    n_cmp++; if (valid_cnt - v0 !== 1) begin n_bad++; $display("FAIL basic_pulses: got %0d expected 1", valid_cnt - v0); end
    n_cmp++; if (fields !== 16'h5A3C) begin n_bad++; $display("FAIL basic_fields: got %h expected %h", fields, 16'h5A3C); end
  endtask

  task automatic test_glitch;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    @(posedge clock);
    #1 s_in = 1'b0;
    idle(20);
    @(negedge clock);
    n_cmp++; if (valid_cnt !== v0) begin n_bad++; $display("FAIL glitch_valid: got %0d expected %0d", valid_cnt, v0); end
    n_cmp++; if (err_cnt !== e0) begin n_bad++; $display("FAIL glitch_err: got %0d expected %0d", err_cnt, e0); end
    n_cmp++; if (fields !== 16'h5A3C) begin n_bad++; $display("FAIL glitch_fields: got %h expected %h", fields, 16'h5A3C); end
    n_cmp++; if (db_estado_rx !== 2'd0) begin n_bad++; $display("FAIL glitch_rxstate: got %0d expected 0", db_estado_rx); end
  endtask

  task automatic test_stop_err;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'h12, 1'b0);
    idle(12);
    @(negedge clock);
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL stoperr_pulse: got %0d expected 1", err_cnt - e0); end
    n_cmp++; if (fields !== 16'h5A3C) begin n_bad++; $display("FAIL stoperr_hold: got %h expected %h", fields, 16'h5A3C); end
    send_byte(8'h0F, 1'b1);
    send_byte(8'hF0, 1'b1);
    idle(12);
    @(negedge clock);
    n_cmp++; if (valid_cnt - v0 !== 1) begin n_bad++; $display("FAIL stoperr_next_valid: got %0d expected 1", valid_cnt - v0); end
    n_cmp++; if (fields !== 16'h0FF0) begin n_bad++; $display("FAIL stoperr_next_fields: got %h expected %h", fields, 16'h0FF0); end
  endtask

  task automatic test_timeout;
    int v0, e0, t0;
    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'h81, 1'b1);
    @(negedge clock);
    t0 = cyc;
    repeat (99) @(posedge clock);
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL timeout_pulse: got %0d expected 1", err_cnt - e0); end
    n_cmp++; if ((last_err_cyc - t0) < 78 || (last_err_cyc - t0) > 86) begin
      n_bad++; $display("FAIL timeout_delay: got %0d expected 78..86", last_err_cyc - t0);
    end
    send_byte(8'h22, 1'b1);
    idle(30);
    @(negedge clock);
    n_cmp++; if (valid_cnt !== v0) begin n_bad++; $display("FAIL timeout_no_valid: got %0d expected %0d", valid_cnt, v0); end
    n_cmp++; if (fields !== 16'h0FF0) begin n_bad++; $display("FAIL timeout_hold: got %h expected %h", fields, 16'h0FF0); end
    idle(90);
    @(negedge clock);
    n_cmp++; if (err_cnt - e0 !== 2) begin n_bad++; $display("FAIL timeout_new_hi: got %0d expected 2", err_cnt - e0); end
  endtask

  task automatic test_back_to_back;
    int v0, e0, q0;
    v0 = valid_cnt; e0 = err_cnt; q0 = vq.size();
    send_byte(8'hAA, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h55, 1'b1);
    idle(12);
    @(negedge clock);
    n_cmp++; if (valid_cnt - v0 !== 2) begin n_bad++; $display("FAIL b2b_count: got %0d expected 2", valid_cnt - v0); end
    n_cmp++; if (err_cnt !== e0) begin n_bad++; $display("FAIL b2b_err: got %0d expected %0d", err_cnt, e0); end
    n_cmp++; if (vq[q0] !== 16'hAAAA) begin n_bad++; $display("FAIL b2b_first: got %h expected %h", vq[q0], 16'hAAAA); end
    n_cmp++; if (vq[q0+1] !== 16'h5555) begin n_bad++; $display("FAIL b2b_second: got %h expected %h", vq[q0+1], 16'h5555); end
  endtask

  task automatic test_reset_mid_frame;
    logic [9:0] f;
    int v0, e0;
    send_byte(8'h11, 1'b1);
    f = {1'b1, 8'h99, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1 s_in = f[i];
      repeat (CPB - 1) @(posedge clock);
    end
    @(posedge clock);
    #1 s_in = f[5];
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (fields !== 16'h0000) begin n_bad++; $display("FAIL rst_mid_fields: got %h expected %h", fields, 16'h0000); end
    n_cmp++; if (db_estado_rx !== 2'd0) begin n_bad++; $display("FAIL rst_mid_rxstate: got %0d expected 0", db_estado_rx); end
    s_in = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    v0 = valid_cnt; e0 = err_cnt;
    idle(20);
    @(negedge clock);
    n_cmp++; if (valid_cnt !== v0 || err_cnt !== e0) begin
      n_bad++; $display("FAIL rst_mid_quiet: got valid %0d err %0d expected %0d %0d", valid_cnt, err_cnt, v0, e0);
    end
    send_byte(8'hC3, 1'b1);
    send_byte(8'hA5, 1'b1);
    idle(12);
    @(negedge clock);
    n_cmp++; if (valid_cnt - v0 !== 1) begin n_bad++; $display("FAIL rst_mid_valid: got %0d expected 1", valid_cnt - v0); end
    n_cmp++; if (fields !== 16'hC3A5) begin n_bad++; $display("FAIL rst_mid_frame: got %h expected %h", fields, 16'hC3A5); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_stop_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL valid_err_overlap: got %0d expected 0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200).
REQ-002 Parameter TIMEOUT_CLKS, default 20*434, maximum idle cycles allowed between byte 1 stop bit and byte 2 start bit.
REQ-003 clock  input  1  single system clock, rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-low.
REQ-005 s_in  input  1  serial line, idle high, 8N1, LSB first.
REQ-006 estado  output  4  frame bits [15:12].
REQ-007 macro  output  4  frame bits [11:8].
REQ-008 micro  output  4  frame bits [7:4].
REQ-009 resultado_macro  output  2  frame bits [3:2].
REQ-010 resultado_jogo  output  2  frame bits [1:0].
REQ-011 frame_valid  output  1  one-cycle pulse: new frame loaded into the field outputs.
REQ-012 frame_err  output  1  one-cycle pulse: byte or frame discarded.
REQ-013 db_estado_rx  output  2  current byte-receiver state code, for debug.

Function
REQ-014 s_in SHALL pass through a 2-flop synchronizer (reset value 1) before any use.
REQ-015 The byte receiver SHALL use states IDLE=0, START=1, DATA=2, STOP=3, with a bit-timer counter and a 3-bit bit index.
REQ-016 IDLE->START SHALL occur on a synchronized falling edge; START SHALL re-sample at CLKS_PER_BIT/2, going to DATA if low and back to IDLE (false start, no error) if high.
REQ-017 DATA SHALL sample each of 8 bits every CLKS_PER_BIT cycles at mid-bit, shifting LSB first, then enter STOP.
REQ-018 STOP SHALL sample at mid-bit: 1 -> byte accepted (one-cycle internal byte_done); 0 -> frame_err pulse, byte dropped; both cases SHALL return to IDLE.
REQ-019 The frame assembler SHALL have states WAIT_HI and WAIT_LO; the first accepted byte is the frame high byte [15:8], the second the low byte [7:0].
REQ-020 In WAIT_LO, a timeout counter SHALL count while the byte receiver is IDLE; reaching TIMEOUT_CLKS SHALL pulse frame_err, discard the high byte and return to WAIT_HI.
REQ-021 A stop-bit error in either state SHALL return the assembler to WAIT_HI.
REQ-022 On byte_done in WAIT_LO, the field outputs SHALL load {hi, lo} and frame_valid SHALL pulse in the cycle after the byte-2 stop sample (latency 1 clock).
REQ-023 Field outputs SHALL hold the last valid frame until the next frame_valid; discarded bytes SHALL never alter them.
REQ-024 frame_valid and frame_err SHALL never be asserted in the same cycle; timeout and stop error coinciding SHALL produce a single frame_err pulse.
REQ-025 Back-to-back frames with zero idle bits between stop and the next start SHALL be received without loss.
REQ-026 The bit timer SHALL be wide enough for CLKS_PER_BIT-1 and the timeout counter wide enough for TIMEOUT_CLKS; neither SHALL wrap.

Reset
REQ-027 While reset=0: both FSMs SHALL be in IDLE/WAIT_HI, all counters 0, all field outputs 0, frame_valid=0, frame_err=0, db_estado_rx=0.
REQ-028 Reset asserted mid-byte or mid-frame SHALL discard partial data; after release, reception SHALL resume only at the next falling edge.

Structure
REQ-029 Shared package jogao_pkg SHALL hold field widths, frame bit positions and the rx/assembler state encodings.
REQ-030 The byte receiver SHALL be sub-module uart_rx_byte (outputs data[7:0], byte_done, stop_err, state); uart_frame_rx SHALL contain the assembler, timeout and output registers.

Verification (CLKS_PER_BIT=4, TIMEOUT_CLKS=80)
REQ-031 Send 0x5A then 0x3C -> one frame_valid pulse; estado=5, macro=A, micro=3, resultado_macro=3, resultado_jogo=0.
REQ-032 0.25-bit low glitch on idle line -> no frame_valid, no frame_err, outputs unchanged.
REQ-033 Byte 0x12 with stop bit 0 -> frame_err pulse; then frame 0x0F 0xF0 -> estado=0, macro=F, micro=F, resultado_macro=0, resultado_jogo=0.
REQ-034 Send 0x81, wait 100 cycles, send 0x22 -> frame_err at cycle 80 of idle; 0x22 taken as a new high byte, no frame_valid.
REQ-035 Frames 0xAAAA and 0x5555 sent back-to-back with no idle gap -> two frame_valid pulses with correct fields.
REQ-036 Reset pulsed during bit 4 of byte 2 -> outputs 0, then a clean frame 0xC3A5 decodes as estado=C, macro=3, micro=A, resultado_macro=1, resultado_jogo=1.
